clap_sound_gen: RTL and testbench

Playback-side counterpart of the clap detection path: converts a single-cycle trigger (typically a detected-clap pulse) into a decaying percussive burst of 9-bit offset-binary amplitude samples centred at 256. It drives the audio output stage (PWM/DAC) and gives audible confirmation of detected claps. The burst carrier is LFSR noise or a square tone, with a linearly decaying envelope.

---
 rtl/clap_pkg.sv | 17 +
 rtl/clap_lfsr16.sv | 21 ++
 rtl/clap_sound_gen.sv | 156 +++++++++++++++
 tb/tb_clap_sound_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clap_pkg.sv
// Shared constants and types for the clap sound generator.
package clap_pkg;

    // Offset-binary midpoint: the value that means silence.
    localparam logic [8:0] AMP_CENTER = 9'd256;

    // Noise carrier seed and feedback taps (x^16+x^14+x^13+x^11+1).
    // The register shifts toward bit 0, so the taps land on bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/clap_lfsr16.sv
// 16-bit Fibonacci LFSR used as the noise carrier.
// It shifts toward bit 0 and feeds the tap parity back into bit 15.
module clap_lfsr16
    import clap_pkg::*;
(
    input  logic        M_CLK,
    input  logic        rst_n_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    // Step the register once for every enabled cycle.
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) begin
            state_o <= LFSR_SEED;
        end else if (adv_i) begin
            state_o <= {^(state_o & LFSR_TAPS), state_o[15:1]};
        end
    end

endmodule

// File: rtl/clap_sound_gen.sv
// Clap sound generator: turns a one-cycle trigger into a decaying burst of
// 9-bit offset-binary samples centred at 256.
// Build option: define CLAP_GEN_NOISE_EN for an LFSR noise carrier; without
// it the carrier is a square tone of TONE_HALF samples per half period.
//
// Handshake: trig_i is a plain level sampled on every edge (no ready);
// sample_stb_o is high for exactly the one cycle in which a new amplitude_o
// first appears, and busy_o stays high for the whole burst.
module clap_sound_gen
    import clap_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int AMP_INIT   = 64,
    parameter int DECAY_STEP = 200,
    parameter int TONE_HALF  = 50
) (
    input  logic       M_CLK,
    input  logic       rst_n_i,
    input  logic       trig_i,
    output logic [8:0] amplitude_o,
    output logic       sample_stb_o,
    output logic       busy_o
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DW = (DECAY_STEP > 1) ? $clog2(DECAY_STEP) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_STEP - 1);
    localparam logic [6:0]    ENV_INIT   = 7'(AMP_INIT);

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] phase_q;
    logic [DW-1:0] decay_q;
    logic [6:0]    env_q;
    logic [6:0]    env_dec;
    logic          sign_q;     // 1 = negative half of the swing
    logic          sign_next;  // carrier sign for the next emitted sample
    logic          phase_wrap;
    logic          decay_wrap;
    logic          burst_end;
    logic          sample_adv;
    logic [8:0]    amp_d;
    logic          stb_d;

    // A sample slot closes when the phase counter reaches its last value.
    assign phase_wrap = (state_q == ACTIVE) && (phase_q == PHASE_LAST);
    assign decay_wrap = (decay_q == DECAY_LAST);
    assign env_dec    = decay_wrap ? (env_q - 7'd1) : env_q;
    // A retrigger always wins over the final decrement.
    assign burst_end  = phase_wrap && decay_wrap && (env_q == 7'd1) && !trig_i;
    // Carrier advances only for emitted samples after the first.
    assign sample_adv = phase_wrap && !trig_i && !burst_end;

`ifdef CLAP_GEN_NOISE_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr_bits;

    clap_lfsr16 u_lfsr (
        .M_CLK   (M_CLK),
        .rst_n_i (rst_n_i),
        .adv_i   (sample_adv),
        .state_o (lfsr_q)
    );

    // After a shift toward bit 0 the new bit 0 is the current bit 1.
    assign sign_next        = lfsr_q[1];
    assign unused_lfsr_bits = ^{lfsr_q[15:2], lfsr_q[0]};
`else
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] tone_q;
    logic          tone_wrap;

    assign tone_wrap = (tone_q == TONE_LAST);
    assign sign_next = tone_wrap ? ~sign_q : sign_q;

    // Count samples within the current tone half period.
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i || trig_i || burst_end) begin
            tone_q <= '0;
        end else if (sample_adv) begin
            tone_q <= tone_wrap ? '0 : tone_q + 1'b1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: a trigger always (re)starts, the last decrement stops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig_i)    state_d = ACTIVE;
            ACTIVE:  if (burst_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values; registered below so trig_i never reaches a pin.
    always_comb begin
        amp_d = amplitude_o;
        stb_d = 1'b0;
        if (trig_i) begin
            amp_d = AMP_CENTER + {2'b00, ENV_INIT};
            stb_d = 1'b1;
        end else if (burst_end) begin
            amp_d = AMP_CENTER;
        end else if (sample_adv) begin
            amp_d = sign_next ? (AMP_CENTER - {2'b00, env_dec})
                              : (AMP_CENTER + {2'b00, env_dec});
            stb_d = 1'b1;
        end
    end

    // Phase, decay, envelope and sign bookkeeping.
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) begin
            phase_q <= '0;
            decay_q <= '0;
            env_q   <= '0;
            sign_q  <= 1'b0;
        end else if (trig_i) begin
            phase_q <= '0;
            decay_q <= '0;
            env_q   <= ENV_INIT;
            sign_q  <= 1'b0;
        end else if (phase_wrap) begin
            phase_q <= '0;
            decay_q <= decay_wrap ? '0 : decay_q + 1'b1;
            env_q   <= env_dec;
            sign_q  <= burst_end ? 1'b0 : sign_next;
        end else if (state_q == ACTIVE) begin
            phase_q <= phase_q + 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge M_CLK) begin
        if (!rst_n_i) begin
            amplitude_o  <= AMP_CENTER;
            sample_stb_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            amplitude_o  <= amp_d;
            sample_stb_o <= stb_d;
            busy_o       <= (state_d == ACTIVE);
        end
    end

endmodule

// File: tb/tb_clap_sound_gen.sv
// Testbench for clap_sound_gen. A per-cycle behavioural model derives every
// expected output from elapsed time since the last trigger; literal sample
// lists and burst lengths pin that model. Works in both carrier builds
// (CLAP_GEN_NOISE_EN defined or not).
module tb_clap_sound_gen;

    localparam int SAMPLE_DIV = 4;
    localparam int AMP_INIT   = 3;
    localparam int DECAY_STEP = 2;
    localparam int TONE_HALF  = 1;
    localparam int N_SAMPLES  = AMP_INIT * DECAY_STEP;
    localparam int T_END      = N_SAMPLES * SAMPLE_DIV;

    logic       M_CLK = 1'b0;
    logic       rst_n_i;
    logic       trig_i;
    logic [8:0] amplitude_o;
    logic       sample_stb_o;
    logic       busy_o;

    clap_sound_gen #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AMP_INIT   (AMP_INIT),
        .DECAY_STEP (DECAY_STEP),
        .TONE_HALF  (TONE_HALF)
    ) dut (
        .M_CLK        (M_CLK),
        .rst_n_i      (rst_n_i),
        .trig_i       (trig_i),
        .amplitude_o  (amplitude_o),
        .sample_stb_o (sample_stb_o),
        .busy_o       (busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 M_CLK = ~M_CLK;

    // ---------------- counters / scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        check_en = 1'b0;
    logic        cap_en   = 1'b0;
    logic [8:0]  exp_q[$];
    int          busy_run = 0;
    int          last_len = 0;

    // ---------------- behavioural model ----------------
    logic        m_active;
    int          m_e;
    logic [8:0]  m_amp;
    logic        m_busy;
    logic        m_stb;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // Expected outputs after each edge: sample k of a burst appears k*SAMPLE_DIV
    // edges after the trigger edge, envelope AMP_INIT - k/DECAY_STEP.
    always @(posedge M_CLK) begin
        int   k;
        int   env;
        logic neg;
        if (!rst_n_i) begin
            m_active = 1'b0; m_e = 0; m_amp = 9'd256;
            m_busy = 1'b0; m_stb = 1'b0; m_lfsr = 16'hACE1;
        end else if (trig_i) begin
            m_active = 1'b1; m_e = 0; m_busy = 1'b1; m_stb = 1'b1;
            m_amp = 9'(256 + AMP_INIT);
        end else if (m_active) begin
            m_e++;
            if (m_e >= T_END) begin
                m_active = 1'b0; m_busy = 1'b0; m_stb = 1'b0; m_amp = 9'd256;
            end else if (m_e % SAMPLE_DIV == 0) begin
                k = m_e / SAMPLE_DIV;
`ifdef CLAP_GEN_NOISE_EN
                m_lfsr = lfsr_step(m_lfsr);
                neg = m_lfsr[0];
`else
                neg = ((k / TONE_HALF) % 2) == 1;
`endif
                env = AMP_INIT - k / DECAY_STEP;
                m_amp = neg ? 9'(256 - env) : 9'(256 + env);
                m_stb = 1'b1;
            end else begin
                m_stb = 1'b0;
            end
        end else begin
            m_stb = 1'b0;
        end
    end

    // ---------------- checks ----------------
    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Compare DUT against the model away from the active edge.
    always @(negedge M_CLK) begin
        if (check_en) begin
            check("amplitude", int'(amplitude_o), int'(m_amp));
            check("busy", int'(busy_o), int'(m_busy));
            check("strobe", int'(sample_stb_o), int'(m_stb));
            if (busy_o === 1'b1) begin
                busy_run++;
            end else begin
                if (busy_run > 0) last_len = busy_run;
                busy_run = 0;
            end
            if (cap_en && sample_stb_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("extra_sample", int'(amplitude_o), 256);
                end else begin
                    check("burst_sample", int'(amplitude_o), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge M_CLK);
        #1;
    endtask

    task automatic pulse_trig();
        trig_i = 1'b1;
        @(posedge M_CLK);
        #1;
        trig_i = 1'b0;
    endtask

    // Literal first-burst samples for the build under test.
    task automatic load_expected();
        logic [8:0] lit[6];
`ifdef CLAP_GEN_NOISE_EN
        lit = '{9'd259, 9'd259, 9'd258, 9'd258, 9'd257, 9'd255};
`else
        lit = '{9'd259, 9'd253, 9'd258, 9'd254, 9'd257, 9'd255};
`endif
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(lit[i]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n_i = 1'b0;
        trig_i  = 1'b0;
        repeat (3) @(posedge M_CLK);
        #1;
        check_en = 1'b1;
        rst_n_i  = 1'b1;
        wait_cycles(50);

        // Pin the software LFSR against hand-computed steps.
        check("lfsr_step1", int'(lfsr_step(16'hACE1)), int'(16'h5670));
        check("lfsr_step2", int'(lfsr_step(16'h5670)), int'(16'hAB38));

        // Single burst straight after reset.
        load_expected();
        cap_en = 1'b1;
        pulse_trig();
        wait_cycles(30);
        cap_en = 1'b0;
        check("burst_len", last_len, 24);
        check("burst_samples_left", exp_q.size(), 0);

        // Retrigger 10 cycles into a burst.
        pulse_trig();
        wait_cycles(9);
        pulse_trig();
        wait_cycles(30);
        check("retrig_len", last_len, 34);

        // Reset on cycle 7 of a burst, then a full burst from fresh state.
        pulse_trig();
        wait_cycles(6);
        rst_n_i = 1'b0;
        wait_cycles(1);
        rst_n_i = 1'b1;
        wait_cycles(2);
        check("reset_cut_len", last_len, 7);
        wait_cycles(5);
        load_expected();
        cap_en = 1'b1;
        pulse_trig();
        wait_cycles(30);
        cap_en = 1'b0;
        check("post_reset_len", last_len, 24);
        check("post_reset_samples_left", exp_q.size(), 0);

        // Retrigger colliding with the final decrement.
        pulse_trig();
        wait_cycles(23);
        pulse_trig();
        wait_cycles(30);
        check("retrig_at_end_len", last_len, 48);

        // Retrigger colliding with an ordinary sample wrap.
        pulse_trig();
        wait_cycles(3);
        pulse_trig();
        wait_cycles(30);
        check("retrig_at_wrap_len", last_len, 28);

        // Random triggers and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            trig_i  = ($urandom_range(0, 39) == 0);
            rst_n_i = ($urandom_range(0, 299) != 0);
            wait_cycles(1);
        end
        trig_i  = 1'b0;
        rst_n_i = 1'b1;
        wait_cycles(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
